// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for an N-digit common-cathode
//               7-segment display bank. A shadow copy of the BCD value is
//               scanned one digit per slot. Each slot is a blanking gap
//               followed by a show phase. The shadow copy is refreshed only at
//               frame boundaries, so a frame never shows a mix of old and new
//               data.
// Options     : `define SEG_LEAD_ZERO_BLANK_EN to suppress leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
    parameter int DIGITS = 8,     // digit positions scanned (1..8)
    parameter int DIV    = 1000,  // clk cycles per digit slot, blank + show
    parameter int BLANK  = 16     // clk cycles per slot with all cathodes off
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    output logic                  load_ack,
    output logic [7:0]            SEG,
    output logic [DIGITS-1:0]     CAT,
    output logic                  frame_done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_SHOW_LEN = DIV - BLANK;
    // The slot counter never exceeds DIV-1, so DIV+1 values are always enough.
    localparam int c_CW       = $clog2(DIV + 1);
    localparam int c_IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK - 1);
    localparam logic [c_CW-1:0] c_SHOW_LAST  = c_CW'(c_SHOW_LEN - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(DIGITS - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE    = c_IW'(1);

    // Scan state encoding
    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_SHOW  = 1'b1;

    // ------------------------------------------------------------------------
    // BCD to 7-segment decode, segment order {g,f,e,d,c,b,a}
    // Codes 10..15 light no segments.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] i_d);
        logic [6:0] v_seg;
        case (i_d)
            4'd0:    v_seg = 7'h3F;
            4'd1:    v_seg = 7'h06;
            4'd2:    v_seg = 7'h5B;
            4'd3:    v_seg = 7'h4F;
            4'd4:    v_seg = 7'h66;
            4'd5:    v_seg = 7'h6D;
            4'd6:    v_seg = 7'h7D;
            4'd7:    v_seg = 7'h07;
            4'd8:    v_seg = 7'h7F;
            4'd9:    v_seg = 7'h6F;
            default: v_seg = 7'h00;
        endcase
        return v_seg;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [c_IW-1:0]       r_idx;

    logic [4*DIGITS-1:0]   r_bcd;
    logic [DIGITS-1:0]     r_dp;
    logic [DIGITS-1:0]     r_en;

    logic [7:0]            r_seg;
    logic [DIGITS-1:0]     r_cat;
    logic                  r_load_ack;
    logic                  r_frame_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                  w_blank_end;
    logic                  w_show_end;
    logic                  w_frame_end;

    logic [3:0]            w_nib;
    logic                  w_dp;
    logic                  w_en;
    logic                  w_lz;
    logic [DIGITS-1:0]     w_lz_mask;
    logic [DIGITS-1:0]     w_cat_sel;

    logic [7:0]            w_show_seg;
    logic [DIGITS-1:0]     w_show_cat;

    // Slot phase boundaries. The frame ends on the last show cycle of the top digit.
    always_comb begin
        w_blank_end = (r_state == c_ST_BLANK) && (r_cnt == c_BLANK_LAST);
        w_show_end  = (r_state == c_ST_SHOW)  && (r_cnt == c_SHOW_LAST);
        w_frame_end = w_show_end && (r_idx == c_IDX_LAST);
    end

    // Select the shadow nibble, dp and enable for the current digit, and build its one-hot-low cathode pattern.
    always_comb begin
        w_nib     = 4'h0;
        w_dp      = 1'b0;
        w_en      = 1'b0;
        w_lz      = 1'b0;
        w_cat_sel = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_nib        = r_bcd[4*i +: 4];
                w_dp         = r_dp[i];
                w_en         = r_en[i];
                w_lz         = w_lz_mask[i];
                w_cat_sel[i] = 1'b0;
            end
        end
    end

`ifdef SEG_LEAD_ZERO_BLANK_EN
    // Walk down from the top digit. Enabled zero digits stay suppressed until the first enabled nonzero digit.
    always_comb begin
        logic v_run;
        w_lz_mask = '0;
        v_run     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (r_en[i] && (r_bcd[4*i +: 4] != 4'h0)) begin
                v_run = 1'b0;
            end
            // Disabled digits are dark anyway. Only enabled digits can end the run.
            w_lz_mask[i] = v_run && (r_bcd[4*i +: 4] == 4'h0);
        end
    end
`else
    // Leading zeros are displayed like any other digit.
    always_comb begin
        w_lz_mask = '0;
    end
`endif

    // Segment and cathode values for the show phase of the current digit. A disabled digit stays fully dark.
    always_comb begin
        if (w_en) begin
            w_show_seg = {w_dp, (w_lz ? 7'h00 : f_decode(w_nib))};
            w_show_cat = w_cat_sel;
        end else begin
            w_show_seg = 8'h00;
            w_show_cat = '1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Scan FSM: alternates BLANK and SHOW, counting cycles in each and advancing the digit index after SHOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else if (w_blank_end) begin
            r_state <= c_ST_SHOW;
            r_cnt   <= '0;
        end else if (w_show_end) begin
            r_state <= c_ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= (r_idx == c_IDX_LAST) ? '0 : (r_idx + c_IDX_ONE);
        end else begin
            r_cnt   <= r_cnt + c_CNT_ONE;
        end
    end

    // Registered pin drive. Values change on the edge that enters a state, so each slot lasts exactly DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 8'h00;
            r_cat <= '1;
        end else if (w_blank_end) begin
            r_seg <= w_show_seg;
            r_cat <= w_show_cat;
        end else if (w_show_end) begin
            r_seg <= 8'h00;
            r_cat <= '1;
        end
    end

    // Shadow capture and handshake. A pending load is captured only at a frame boundary; frame_done and load_ack pulse together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd        <= '0;
            r_dp         <= '0;
            r_en         <= '0;
            r_load_ack   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_load_ack   <= 1'b0;
            r_frame_done <= w_frame_end;
            if (w_frame_end && load) begin
                r_bcd      <= bcd_in;
                r_dp       <= dp_in;
                r_en       <= digit_en;
                r_load_ack <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign SEG        = r_seg;
    assign CAT        = r_cat;
    assign load_ack   = r_load_ack;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl
//               (DIGITS=8, DIV=10, BLANK=2). Each digit slot has 2 blank
//               cycles followed by 8 show cycles, so a frame is 80 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int c_DIGITS = 8;
    localparam int c_DIV    = 10;
    localparam int c_BLANK  = 2;
    localparam int c_FRAME  = c_DIGITS * c_DIV;

    logic                   clk;
    logic                   rst_n;
    logic [4*c_DIGITS-1:0]  bcd_in;
    logic [c_DIGITS-1:0]    dp_in;
    logic [c_DIGITS-1:0]    digit_en;
    logic                   load;
    logic                   load_ack;
    logic [7:0]             SEG;
    logic [c_DIGITS-1:0]    CAT;
    logic                   frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Expected per-digit show values for the frame being scanned
    logic [7:0] exp_cat [c_DIGITS];
    logic [7:0] exp_seg [c_DIGITS];

    // Data applied by a mid-frame load request
    logic [31:0] pend_bcd;
    logic [7:0]  pend_dp;
    logic [7:0]  pend_en;

    seg_scan_ctrl #(
        .DIGITS (c_DIGITS),
        .DIV    (c_DIV),
        .BLANK  (c_BLANK)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .load_ack   (load_ack),
        .SEG        (SEG),
        .CAT        (CAT),
        .frame_done (frame_done)
    );

    // 10-time-unit clock. Rising edges at 5, 15, ... and samples taken on falling edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference segment table
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        return t[d];
    endfunction

    // Build the expected show values for a given shadow content
    task automatic set_exp(input logic [31:0] bcd, input logic [7:0] dp, input logic [7:0] en);
        logic       seen_nz;
        logic [3:0] nib;
        logic       lz;
        seen_nz = 1'b0;
        for (int k = c_DIGITS - 1; k >= 0; k--) begin
            nib = bcd[4*k +: 4];
            if (en[k] && nib != 4'h0) seen_nz = 1'b1;
`ifdef SEG_LEAD_ZERO_BLANK_EN
            lz = !seen_nz && (nib == 4'h0) && (k != 0);
`else
            lz = 1'b0;
`endif
            if (en[k]) begin
                exp_cat[k] = ~(8'h01 << k);
                exp_seg[k] = {dp[k], (lz ? 7'h00 : seg_of(nib))};
            end else begin
                exp_cat[k] = 8'hFF;
                exp_seg[k] = 8'h00;
            end
        end
    endtask

    // Step falling edges until frame_done is seen. Returns the number of cycles taken.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 300);
        if (!frame_done) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    // Check a whole frame cycle by cycle. Entry is on the frame_done cycle (blank cycle 0 of digit 0).
    // Exit is on the next frame_done cycle.
    task automatic scan_frame(input logic exp_ack, input int load_at_k);
        logic [15:0] exp_pins;
        logic        first;
        for (int k = 0; k < c_DIGITS; k++) begin
            for (int c = 0; c < c_DIV; c++) begin
                first = (k == 0) && (c == 0);
                if (k == load_at_k && c == 0) begin
                    bcd_in   = pend_bcd;
                    dp_in    = pend_dp;
                    digit_en = pend_en;
                    load     = 1'b1;
                end
                exp_pins = (c < c_BLANK) ? 16'hFF00 : {exp_cat[k], exp_seg[k]};
                chk($sformatf("pins_d%0d_c%0d", k, c), {16'h0, CAT, SEG}, {16'h0, exp_pins});
                chk($sformatf("frame_done_d%0d_c%0d", k, c), {31'h0, frame_done}, {31'h0, first});
                chk($sformatf("load_ack_d%0d_c%0d", k, c), {31'h0, load_ack},
                    {31'h0, (first ? exp_ack : 1'b0)});
                if (first && load_at_k != 0) load = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_in   = '0;
        dp_in    = '0;
        digit_en = '0;
        pend_bcd = '0;
        pend_dp  = '0;
        pend_en  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", {24'h0, SEG}, 32'h00);
        chk("rst_cat", {24'h0, CAT}, 32'hFF);
        chk("rst_ack", {31'h0, load_ack}, 32'h0);
        chk("rst_fd",  {31'h0, frame_done}, 32'h0);

        // Idle: first frame boundary 80 cycles after release, then a fully dark frame
        rst_n = 1'b1;
        wait_frame(n);
        chk("first_frame_len", n, c_FRAME);
        set_exp(32'h0, 8'h00, 8'h00);
        scan_frame(1'b0, -1);

        // Basic scan of 0x87654321
        bcd_in = 32'h87654321; dp_in = 8'h00; digit_en = 8'hFF; load = 1'b1;
        wait_frame(n);
        chk("frame_period", n, c_FRAME);
        set_exp(32'h87654321, 8'h00, 8'hFF);
        scan_frame(1'b1, -1);

        // Mid-frame load of 0x11111111: current frame stays unchanged, the next frame uses the new value
        pend_bcd = 32'h11111111; pend_dp = 8'h00; pend_en = 8'hFF;
        scan_frame(1'b0, 3);
        set_exp(32'h11111111, 8'h00, 8'hFF);
        scan_frame(1'b1, -1);

        // Invalid code, decimal point and a disabled digit
        bcd_in = 32'h8765432C; dp_in = 8'h01; digit_en = 8'hFD; load = 1'b1;
        wait_frame(n);
        set_exp(32'h8765432C, 8'h01, 8'hFD);
        chk("tbl_d0_seg", {24'h0, exp_seg[0]}, 32'h80);
        scan_frame(1'b1, -1);

        // Async reset during the show phase of digit 5
        repeat (5 * c_DIV + 5) @(negedge clk);
        chk("pre_rst_pins", {16'h0, CAT, SEG}, 32'hDF7D);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pins", {16'h0, CAT, SEG}, 32'hFF00);
        chk("async_rst_fd",   {31'h0, frame_done}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frame(n);
        chk("post_rst_frame_len", n, c_FRAME);
        set_exp(32'h0, 8'h00, 8'h00);
        scan_frame(1'b0, -1);

        // Leading zeros on 0x00000400
        bcd_in = 32'h00000400; dp_in = 8'h00; digit_en = 8'hFF; load = 1'b1;
        wait_frame(n);
        set_exp(32'h00000400, 8'h00, 8'hFF);
        scan_frame(1'b1, -1);

        // A load dropped before the boundary is ignored
        bcd_in = 32'h22222222; load = 1'b1;
        repeat (30) @(negedge clk);
        load = 1'b0;
        wait_frame(n);
        scan_frame(1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
